// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for serial_adder_ctrl.
// The requester drives start/a/b/cin; the adder returns busy/done/sum/cout.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder (two half adders plus OR) is
// stepped LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_cout;

    always_comb begin
        ha1_s   = op_a_q[0] ^ op_b_q[0];
        ha1_c   = op_a_q[0] & op_b_q[0];
        ha2_s   = ha1_s ^ carry_q;
        ha2_c   = ha1_s & carry_q;
        fa_cout = ha1_c | ha2_c;
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.b;
                    carry_d = bus.cin;
                    count_d = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                carry_d = fa_cout;
                sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                if (count_q == LAST_BIT) begin
                    // Carry-out is latched on the final bit so it is already
                    // valid alongside sum while done is high.
                    cout_d  = fa_cout;
                    count_d = '0;
                    state_d = S_FIN;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        bus.busy = (state_q == S_ADD);
        bus.done = (state_q == S_FIN);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results and
// done cycles from an arithmetic model; a negedge monitor pops and compares.
module tb_serial_adder_ctrl;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned W1    = WIDTH + 1;
    localparam int unsigned N_RAND_OPS = 1000;

    typedef struct {
        logic [WIDTH:0] res;
        int unsigned    cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t           q[$];
    int unsigned    vectors     = 0;
    int unsigned    miscompares = 0;
    int unsigned    next_free   = 0;
    int unsigned    cur_e       = 0;
    bit             cur_valid   = 1'b0;
    int unsigned    accepted    = 0;
    logic [WIDTH:0] last_res    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at posedge+#1; the start level set here is seen on the next edge.
    task automatic drive_cycle(input logic st, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic ci);
        int unsigned e_edge;
        exp_t        x;
        bus.start = st;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        e_edge    = cyc + 1;
        if (st && rst_n && e_edge >= next_free) begin
            x.res = W1'(av) + W1'(bv) + W1'(ci);
            x.cyc = e_edge + WIDTH;
            q.push_back(x);
            cur_e     = e_edge;
            cur_valid = 1'b1;
            next_free = e_edge + WIDTH + 2;
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            drive_cycle(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci);
        drive_cycle(1'b1, av, bv, ci);
        idle_cycles(WIDTH + 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_sum"},  64'(bus.sum),  64'(0));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(0));
    endtask

    logic exp_busy;
    logic exp_done;
    exp_t popped;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_busy = cur_valid && (cyc >= cur_e) && (cyc < cur_e + WIDTH);
            exp_done = (q.size() > 0) && (q[0].cyc == cyc);
            chk("busy", 64'(bus.busy), 64'(exp_busy));
            chk("done", 64'(bus.done), 64'(exp_done));
            if (exp_done) begin
                popped   = q.pop_front();
                last_res = popped.res;
                if (bus.done)
                    chk("result", 64'({bus.cout, bus.sum}), 64'(popped.res));
            end else if (!exp_busy) begin
                chk("hold", 64'({bus.cout, bus.sum}), 64'(last_res));
            end
        end
    end

    initial begin
        int unsigned start_acc;
        int unsigned guard;
        logic        st;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n     = 1'b1;
        next_free = cyc + 1;

        run_op(8'h3C, 8'h05, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);

        // second start mid-operation must be ignored
        drive_cycle(1'b1, 8'h12, 8'h34, 1'b0);
        idle_cycles(3);
        drive_cycle(1'b1, 8'hAA, 8'h55, 1'b1);
        idle_cycles(WIDTH + 2);

        // abort an operation with reset in its third cycle
        drive_cycle(1'b1, 8'hFF, 8'hFF, 1'b0);
        idle_cycles(2);
        #2;
        rst_n = 1'b0;
        q.delete();
        cur_valid = 1'b0;
        last_res  = '0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        next_free = cyc + 1;
        idle_cycles(WIDTH + 2);
        run_op(8'h5A, 8'hC3, 1'b1);

        // random ops: alternate held-high start with sparse random pulses
        start_acc = accepted;
        guard     = 0;
        while ((accepted - start_acc) < N_RAND_OPS && guard < 60000) begin
            if (((guard / 200) % 3) == 0)
                st = 1'b1;
            else
                st = ($urandom_range(0, 2) == 0);
            drive_cycle(st, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            guard++;
        end
        chk("rand_ops", 64'(accepted - start_acc), 64'(N_RAND_OPS));

        idle_cycles(WIDTH + 4);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
